// File: rtl/fma_arbiter.sv
// fma_arbiter: round-robin front end that shares one combinational fp32 FMA
// (out = a*b + c) between NUM_REQ requesters. Operands are registered before
// the FMA and the result after it. The response comes back tagged with the
// issuing requester's index over a valid/ready channel.
module fma_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_W       = 16,
   localparam int TAG_W      = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [32*NUM_REQ-1:0] req_c,
   output logic [31:0]          fma_a,
   output logic [31:0]          fma_b,
   output logic [31:0]          fma_c,
   input  logic [31:0]          fma_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_data,
   output logic [TAG_W-1:0]     rsp_tag,
   output logic                 busy,
   output logic [CNT_W-1:0]     op_count
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [3:0]       LAST_EXEC = 4'(EXEC_CYCLES - 1);
   localparam logic [TAG_W-1:0] LAST_REQ  = TAG_W'(NUM_REQ - 1);

   state_t           state;
   logic [3:0]       exec_cnt;
   logic [TAG_W-1:0] rr_ptr;
   logic [TAG_W-1:0] winner;
   logic [TAG_W-1:0] tag_q;
   logic             any_valid;
   int               scan_idx;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic [31:0]      op_c;
   logic [31:0]      res_q;

   // The FMA sees the operand registers directly, so its inputs only move on accept.
   assign fma_a    = op_a;
   assign fma_b    = op_b;
   assign fma_c    = op_c;
   assign rsp_data = res_q;
   assign rsp_tag  = tag_q;

   // Pick the first valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      any_valid = 1'b0;
      winner    = '0;
      scan_idx  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!any_valid && req_valid[scan_idx]) begin
            any_valid = 1'b1;
            winner    = TAG_W'(scan_idx);
         end
      end
   end

   // Grant is combinational so the winner sees req_ready in the same cycle it asks.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && any_valid) req_ready[winner] = 1'b1;
   end

   // Control FSM with the operand, result, tag and counter registers it owns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are reset too, so outputs are defined
         // zeros right after reset rather than leftovers from an abandoned op.
         state     <= IDLE;
         rr_ptr    <= '0;
         exec_cnt  <= '0;
         tag_q     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_c      <= '0;
         res_q     <= '0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
         op_count  <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
         unique case (state)
            IDLE: begin
               if (any_valid) begin
                  op_a     <= req_a[32*winner +: 32];
                  op_b     <= req_b[32*winner +: 32];
                  op_c     <= req_c[32*winner +: 32];
                  tag_q    <= winner;
                  rr_ptr   <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
                  exec_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               exec_cnt <= exec_cnt + 1'b1;
               if (exec_cnt == LAST_EXEC) begin
                  res_q     <= fma_out;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  op_count  <= op_count + 1'b1;
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fma_arbiter.sv
// Testbench for fma_arbiter. Two instances share one stimulus bus: u0 runs with
// EXEC_CYCLES=1, CNT_W=16 and u1 with EXEC_CYCLES=4, CNT_W=4. The bench stub FMA
// computes a^b^c. A scoreboard queues the expected tag/data at each grant and
// pops one entry per completed response.
module tb_fma_arbiter;

   localparam int N = 4;

   typedef struct packed {
      logic [1:0]  tag;
      logic [31:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid;
   logic [32*N-1:0] req_a, req_b, req_c;
   logic            rsp_ready;
   logic [31:0]     glitch;
   logic            sel;

   logic [N-1:0] rr0, rr1;
   logic [31:0]  fa0, fb0, fc0, fo0, rd0;
   logic [31:0]  fa1, fb1, fc1, fo1, rd1;
   logic         rv0, rv1, bz0, bz1;
   logic [1:0]   rt0, rt1;
   logic [15:0]  oc0;
   logic [3:0]   oc1;

   logic [N-1:0] obs_ready;
   logic         obs_valid, obs_busy;
   logic [31:0]  obs_data, obs_fa, obs_fb, obs_fc;
   logic [1:0]   obs_tag;
   logic [15:0]  obs_cnt;

   always #5 clk = ~clk;

   assign fo0 = fa0 ^ fb0 ^ fc0;
   assign fo1 = fa1 ^ fb1 ^ fc1 ^ glitch;

   fma_arbiter #(.NUM_REQ(N), .EXEC_CYCLES(1), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr0),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .fma_a(fa0), .fma_b(fb0), .fma_c(fc0), .fma_out(fo0),
      .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_data(rd0), .rsp_tag(rt0),
      .busy(bz0), .op_count(oc0)
   );

   fma_arbiter #(.NUM_REQ(N), .EXEC_CYCLES(4), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr1),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .fma_a(fa1), .fma_b(fb1), .fma_c(fc1), .fma_out(fo1),
      .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .rsp_tag(rt1),
      .busy(bz1), .op_count(oc1)
   );

   // Route the instance under test onto one set of observation signals.
   always_comb begin
      if (sel) begin
         obs_ready = rr1; obs_valid = rv1; obs_busy = bz1; obs_data = rd1;
         obs_tag = rt1; obs_cnt = {12'h000, oc1};
         obs_fa = fa1; obs_fb = fb1; obs_fc = fc1;
      end else begin
         obs_ready = rr0; obs_valid = rv0; obs_busy = bz0; obs_data = rd0;
         obs_tag = rt0; obs_cnt = oc0;
         obs_fa = fa0; obs_fb = fb0; obs_fc = fc0;
      end
   end

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   int   rr_m = 0;
   int   cnt_m = 0;
   int   grants[N];
   int   granted = -1;
   bit   hold_all = 1'b0;

   // Values sampled on the falling edge of the last stepped cycle.
   logic [N-1:0] s_ready;
   logic         s_valid, s_busy;
   logic [31:0]  s_data, s_fa, s_fb, s_fc;
   logic [1:0]   s_tag;
   logic [15:0]  s_cnt;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_c[32*i +: 32] = c;
   endtask

   function automatic int winner_model();
      for (int k = 0; k < N; k++) begin
         int i;
         i = (rr_m + k) % N;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   // One clock cycle: sample and score on the falling edge, then update requesters after the rising edge.
   task automatic step();
      int   w;
      exp_t e;
      logic [15:0] mask;
      @(negedge clk);
      mask = sel ? 16'h000F : 16'hFFFF;
      s_ready = obs_ready; s_valid = obs_valid; s_busy = obs_busy; s_data = obs_data;
      s_tag = obs_tag; s_cnt = obs_cnt; s_fa = obs_fa; s_fb = obs_fb; s_fc = obs_fc;
      check("op_count", obs_cnt, 64'(16'(cnt_m) & mask));
      granted = -1;
      if (obs_ready != '0) begin
         w = winner_model();
         check("grant_onehot", obs_ready, (w < 0) ? 64'd0 : (64'd1 << w));
         if (w >= 0) begin
            e.tag  = 2'(w);
            e.data = req_a[32*w +: 32] ^ req_b[32*w +: 32] ^ req_c[32*w +: 32];
            sb.push_back(e);
            grants[w]++;
            rr_m    = (w + 1) % N;
            granted = w;
         end
      end
      if (obs_valid && rsp_ready) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL rsp_unexpected observed tag=%0d data=%0h expected=no response", obs_tag, obs_data);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_tag", obs_tag, e.tag);
            check("rsp_data", obs_data, e.data);
         end
         cnt_m++;
      end
      @(posedge clk);
      #1;
      if (granted >= 0) begin
         if (hold_all) set_ops(granted, $urandom(), $urandom(), $urandom());
         else req_valid[granted] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req_valid = '0;
      sb.delete();
      rr_m = 0;
      cnt_m = 0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int  g_idx[5];
   int  g_cyc[5];
   int  ng;
   int  n;
   int  g1;
   int  drop_at;
   bit  raised;
   bit  seen_valid;
   logic [31:0] a5, b5, c5, d4;

   initial begin
      sel = 1'b0; req_valid = '0; rsp_ready = 1'b1; glitch = '0;
      req_a = '0; req_b = '0; req_c = '0;
      for (int i = 0; i < N; i++) grants[i] = 0;

      // Reset values
      @(negedge clk);
      check("rst_ready", obs_ready, 0);
      check("rst_valid", obs_valid, 0);
      check("rst_busy", obs_busy, 0);
      check("rst_data", obs_data, 0);
      check("rst_tag", obs_tag, 0);
      check("rst_cnt", obs_cnt, 0);
      check("rst_fma_a", obs_fa, 0);
      check("rst_fma_c", obs_fc, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single op through the EXEC_CYCLES=1 instance
      set_ops(0, 32'h3F800000, 32'h40000000, 32'h40400000);
      req_valid = 4'b0001;
      step();
      check("t2_ready_c0", s_ready, 4'b0001);
      check("t2_valid_c0", s_valid, 0);
      step();
      check("t2_valid_c1", s_valid, 0);
      check("t2_busy_c1", s_busy, 1);
      step();
      check("t2_valid_c2", s_valid, 1);
      check("t2_data_c2", s_data, 32'h3FC00000);
      check("t2_tag_c2", s_tag, 0);
      step();
      check("t2_valid_c3", s_valid, 0);
      check("t2_busy_c3", s_busy, 0);
      check("t2_cnt_c3", s_cnt, 1);

      // All four requesting continuously: order 0,1,2,3,0, one grant every 3 cycles
      do_reset();
      hold_all = 1'b1;
      for (int i = 0; i < N; i++) set_ops(i, $urandom(), $urandom(), $urandom());
      req_valid = 4'b1111;
      ng = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (granted >= 0 && ng < 5) begin
            g_idx[ng] = granted;
            g_cyc[ng] = c;
            ng++;
         end
      end
      req_valid = '0;
      hold_all = 1'b0;
      check("t3_grants", ng, 5);
      for (int k = 0; k < 5; k++) begin
         check("t3_order", g_idx[k], k % N);
         check("t3_spacing", g_cyc[k], 3 * k);
      end
      check("t3_drained", sb.size(), 0);

      // Backpressure: rsp_ready low for 5 cycles in RESP
      set_ops(2, $urandom(), $urandom(), $urandom());
      set_ops(3, $urandom(), $urandom(), $urandom());
      d4 = req_a[95:64] ^ req_b[95:64] ^ req_c[95:64];
      req_valid = 4'b1100;
      step();
      check("t4_grant2", s_ready, 4'b0100);
      step();
      rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         check("t4_hold_valid", s_valid, 1);
         check("t4_hold_data", s_data, d4);
         check("t4_hold_tag", s_tag, 2);
         check("t4_no_ready", s_ready, 0);
      end
      rsp_ready = 1'b1;
      step();
      check("t4_release_valid", s_valid, 1);
      step();
      check("t4_next_grant3", s_ready, 4'b1000);
      n = 0;
      while (sb.size() > 0 && n < 20) begin step(); n++; end
      check("t4_timeout", (n < 20), 1);

      // EXEC_CYCLES=4 instance: one complete op, then reset in the middle of EXEC
      sel = 1'b1;
      do_reset();
      set_ops(0, $urandom(), $urandom(), $urandom());
      req_valid = 4'b0001;
      for (int c = 0; c < 7; c++) step();
      check("t1_cnt_pre", s_cnt, 1);
      set_ops(0, $urandom(), $urandom(), $urandom());
      req_valid = 4'b0001;
      step();
      step();
      step();
      check("t1_busy_pre", s_busy, 1);
      rst_n = 1'b0;
      sb.delete();
      rr_m = 0;
      cnt_m = 0;
      step();
      check("t1_busy", s_busy, 0);
      check("t1_valid", s_valid, 0);
      check("t1_ready", s_ready, 0);
      check("t1_cnt", s_cnt, 0);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         seen_valid = seen_valid | s_valid;
      end
      check("t1_no_rsp", seen_valid, 0);

      // Operands held 4 cycles, late capture ignores a mid-EXEC change on fma_out
      a5 = $urandom(); b5 = $urandom(); c5 = $urandom();
      set_ops(0, a5, b5, c5);
      req_valid = 4'b0001;
      step();
      check("t5_ready_c0", s_ready, 4'b0001);
      set_ops(0, ~a5, ~b5, ~c5);
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) glitch = 32'hDEADBEEF;
         step();
         glitch = '0;
         check("t5_fma_a", s_fa, a5);
         check("t5_fma_b", s_fb, b5);
         check("t5_fma_c", s_fc, c5);
         check("t5_valid_exec", s_valid, 0);
      end
      step();
      check("t5_valid_c5", s_valid, 1);
      check("t5_data_c5", s_data, a5 ^ b5 ^ c5);
      step();
      check("t5_valid_c6", s_valid, 0);
      check("t5_fma_hold", s_fa, a5);

      // Counter wrap at CNT_W=4; req1 raised while busy and dropped before IDLE
      hold_all = 1'b1;
      set_ops(0, $urandom(), $urandom(), $urandom());
      set_ops(1, $urandom(), $urandom(), $urandom());
      set_ops(2, $urandom(), $urandom(), $urandom());
      req_valid = 4'b0101;
      g1 = grants[1];
      raised = 1'b0;
      drop_at = -1;
      n = 0;
      while (cnt_m < 16 && n < 200) begin
         step();
         n++;
         if (granted >= 0 && !raised) begin
            raised = 1'b1;
            req_valid[1] = 1'b1;
            drop_at = n + 2;
         end
         if (n == drop_at) req_valid[1] = 1'b0;
      end
      check("t6_timeout", (n < 200), 1);
      step();
      check("t6_wrap", s_cnt, 0);
      req_valid = '0;
      hold_all = 1'b0;
      n = 0;
      while (sb.size() > 0 && n < 20) begin step(); n++; end
      check("t6_drain_timeout", (n < 20), 1);
      check("t6_req1_never", grants[1], g1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
